// File: rtl/operand_loader_if.sv
// Handshake bundle between the character source, the operand loader and the adder.
interface operand_loader_if #(
    parameter int WIDTH = 5
);
    logic             ch_valid;
    logic [7:0]       ch_data;
    logic             ch_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             op_valid;
    logic             op_ready;
    logic             ovf;
    logic             err;

    // Character source and adder view: offers bytes, accepts operand pairs.
    modport master (
        output ch_valid, ch_data, op_ready,
        input  ch_ready, x, y, op_valid, ovf, err
    );

    // Loader view: accepts bytes, offers operand pairs.
    modport slave (
        input  ch_valid, ch_data, op_ready,
        output ch_ready, x, y, op_valid, ovf, err
    );
endinterface

// File: rtl/operand_loader.sv
// Parses "DD<term>DD<term>" ASCII streams into a binary x/y operand pair.
module operand_loader #(
    parameter int WIDTH       = 5,
    parameter bit STRICT_TERM = 1'b1
) (
    input logic             clk,
    input logic             rst_n,
    operand_loader_if.slave bus
);
    typedef enum logic [2:0] {
        X_TENS,
        X_ONES,
        X_TERM,
        Y_TENS,
        Y_ONES,
        Y_TERM,
        OUT
    } state_t;

    localparam int MAX_VAL = (1 << WIDTH) - 1;

    state_t           state_q, state_d;
    logic [3:0]       tens_q, tens_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             ovf_q, ovf_d;
    logic             err_q, err_d;

    logic             accept;
    logic             isDigit;
    logic             termOk;
    logic [6:0]       value;
    logic             ovfNow;

    // An ASCII digit has high nibble 3, so its low nibble is the digit value.
    assign accept  = bus.ch_valid && (state_q != OUT);
    assign isDigit = (bus.ch_data[7:4] == 4'h3) && (bus.ch_data[3:0] <= 4'd9);
    assign termOk  = !STRICT_TERM || (bus.ch_data == 8'h0A);
    assign value   = 7'(tens_q) * 7'd10 + 7'(bus.ch_data[3:0]);
    assign ovfNow  = ({25'd0, value} > 32'(MAX_VAL));

    // Parser next state: digits and terminators advance, anything malformed restarts the pair.
    always_comb begin
        logic bad;
        bad     = 1'b0;
        state_d = state_q;
        tens_d  = tens_q;
        x_d     = x_q;
        y_d     = y_q;
        ovf_d   = ovf_q;
        err_d   = 1'b0;
        unique case (state_q)
            X_TENS: if (accept) begin
                ovf_d = 1'b0;
                if (isDigit) begin
                    tens_d  = bus.ch_data[3:0];
                    state_d = X_ONES;
                end else begin
                    bad = 1'b1;
                end
            end
            X_ONES: if (accept) begin
                if (isDigit) begin
                    x_d     = WIDTH'(value);
                    ovf_d   = ovfNow;
                    state_d = X_TERM;
                end else begin
                    bad = 1'b1;
                end
            end
            X_TERM: if (accept) begin
                if (termOk) state_d = Y_TENS;
                else        bad     = 1'b1;
            end
            Y_TENS: if (accept) begin
                if (isDigit) begin
                    tens_d  = bus.ch_data[3:0];
                    state_d = Y_ONES;
                end else begin
                    bad = 1'b1;
                end
            end
            Y_ONES: if (accept) begin
                if (isDigit) begin
                    y_d     = WIDTH'(value);
                    ovf_d   = ovf_q | ovfNow;
                    state_d = Y_TERM;
                end else begin
                    bad = 1'b1;
                end
            end
            Y_TERM: if (accept) begin
                if (termOk) state_d = OUT;
                else        bad     = 1'b1;
            end
            OUT: if (bus.op_ready) state_d = X_TENS;
            default: state_d = X_TENS;
        endcase
        if (bad) begin
            err_d   = 1'b1;
            ovf_d   = 1'b0;
            state_d = X_TENS;
        end
    end

    // State and operand registers; reset drops any partial or pending pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= X_TENS;
            tens_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tens_q  <= tens_d;
            x_q     <= x_d;
            y_q     <= y_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    assign bus.ch_ready = (state_q != OUT);
    assign bus.op_valid = (state_q == OUT);
    assign bus.x        = x_q;
    assign bus.y        = y_q;
    assign bus.ovf      = ovf_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_operand_loader.sv
// Bench for operand_loader: strict (index 0) and lenient (index 1) terminator instances.
module tb_operand_loader;
    localparam int W = 5;

    logic clk = 1'b0;
    logic rst_n;

    operand_loader_if #(.WIDTH(W)) busS ();
    operand_loader_if #(.WIDTH(W)) busL ();

    operand_loader #(.WIDTH(W), .STRICT_TERM(1'b1)) dutS (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busS.slave)
    );

    operand_loader #(.WIDTH(W), .STRICT_TERM(1'b0)) dutL (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busL.slave)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: position in the six-byte pair, pending tens digit, expected outputs.
    int mPos[2];
    int mTens[2];
    int mX[2];
    int mY[2];
    bit mOvf[2];
    bit mOut[2];

    // Global guard so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic readyOf(input bit l);
        return l ? busL.ch_ready : busS.ch_ready;
    endfunction

    function automatic logic opReadyOf(input bit l);
        return l ? busL.op_ready : busS.op_ready;
    endfunction

    task automatic drive(input bit l, input logic v, input logic [7:0] d);
        if (l) begin busL.ch_valid = v; busL.ch_data = d; end
        else   begin busS.ch_valid = v; busS.ch_data = d; end
    endtask

    task automatic setOpReady(input bit l, input logic r);
        if (l) busL.op_ready = r;
        else   busS.op_ready = r;
    endtask

    task automatic observe(input bit l, output logic [W-1:0] ox, output logic [W-1:0] oy,
                           output logic ov, output logic oe, output logic oval, output logic ordy);
        if (l) begin
            ox = busL.x; oy = busL.y; ov = busL.ovf; oe = busL.err; oval = busL.op_valid; ordy = busL.ch_ready;
        end else begin
            ox = busS.x; oy = busS.y; ov = busS.ovf; oe = busS.err; oval = busS.op_valid; ordy = busS.ch_ready;
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            mPos[i] = 0; mTens[i] = 0; mX[i] = 0; mY[i] = 0; mOvf[i] = 1'b0; mOut[i] = 1'b0;
        end
    endtask

    // Model of one accepted byte, from the textual format "DD<term>DD<term>".
    task automatic modelAccept(input bit l, input logic [7:0] b, output bit expErr);
        bit digitPos;
        bit isDig;
        bit bad;
        int d;
        int v;
        digitPos = (mPos[l] != 2) && (mPos[l] != 5);
        isDig    = (b >= 8'h30) && (b <= 8'h39);
        d        = int'(b) - 48;
        bad      = digitPos ? !isDig : (l == 1'b0 && b != 8'h0A);
        expErr   = bad;
        if (bad) begin
            mPos[l] = 0;
            mOvf[l] = 1'b0;
            return;
        end
        case (mPos[l])
            0: begin mTens[l] = d; mOvf[l] = 1'b0; end
            1: begin v = mTens[l] * 10 + d; mX[l] = v % (1 << W); mOvf[l] = (v > (1 << W) - 1); end
            3: mTens[l] = d;
            4: begin v = mTens[l] * 10 + d; mY[l] = v % (1 << W); if (v > (1 << W) - 1) mOvf[l] = 1'b1; end
            default: ;
        endcase
        mPos[l]++;
        if (mPos[l] == 6) begin
            mPos[l] = 0;
            mOut[l] = 1'b1;
        end
    endtask

    task automatic checkState(input bit l, input bit expErr, input string tag);
        logic [W-1:0] ox, oy;
        logic ov, oe, oval, ordy;
        observe(l, ox, oy, ov, oe, oval, ordy);
        checkOutput({tag, ".x"},        32'(ox),   32'(mX[l]));
        checkOutput({tag, ".y"},        32'(oy),   32'(mY[l]));
        checkOutput({tag, ".ovf"},      32'(ov),   32'(mOvf[l]));
        checkOutput({tag, ".err"},      32'(oe),   32'(expErr));
        checkOutput({tag, ".op_valid"}, 32'(oval), 32'(mOut[l]));
        checkOutput({tag, ".ch_ready"}, 32'(ordy), 32'(!mOut[l]));
    endtask

    // Advance n cycles with whatever is being driven; valid must be low or the DUT must be in OUT.
    task automatic settle(input bit l, input int n);
        logic rdyBefore;
        for (int i = 0; i < n; i++) begin
            rdyBefore = opReadyOf(l);
            @(posedge clk); #1;
            if (rdyBefore && mOut[l]) mOut[l] = 1'b0;
            checkState(l, 1'b0, "idle");
        end
    endtask

    // Offer one byte and hold it until accepted (bounded); leaves ch_valid high afterwards.
    task automatic applyStimulus(input bit l, input logic [7:0] b);
        int waited;
        logic rdyBefore;
        bit expErr;
        waited = 0;
        drive(l, 1'b1, b);
        while (readyOf(l) !== 1'b1 && waited < 40) begin
            rdyBefore = opReadyOf(l);
            @(posedge clk); #1;
            if (rdyBefore && mOut[l]) mOut[l] = 1'b0;
            checkState(l, 1'b0, "wait");
            waited++;
        end
        if (readyOf(l) !== 1'b1) begin
            checkOutput("chReadyTimeout", 32'(readyOf(l)), 32'd1);
            drive(l, 1'b0, 8'h00);
        end else begin
            @(posedge clk); #1;
            modelAccept(l, b, expErr);
            checkState(l, expErr, "accept");
        end
    endtask

    task automatic sendStr(input bit l, input string s);
        for (int i = 0; i < s.len(); i++) applyStimulus(l, s[i]);
    endtask

    task automatic expectPair(input bit l, input int ex, input int ey, input bit eov, input string tag);
        logic [W-1:0] ox, oy;
        logic ov, oe, oval, ordy;
        observe(l, ox, oy, ov, oe, oval, ordy);
        checkOutput({tag, ".x"},        32'(ox),   32'(ex));
        checkOutput({tag, ".y"},        32'(oy),   32'(ey));
        checkOutput({tag, ".ovf"},      32'(ov),   32'(eov));
        checkOutput({tag, ".op_valid"}, 32'(oval), 32'd1);
    endtask

    initial begin
        logic [W-1:0] ox, oy;
        logic ov, oe, oval, ordy;
        logic [7:0] b;

        modelReset();
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 8'h00);
        setOpReady(1'b0, 1'b1);
        setOpReady(1'b1, 1'b1);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkState(1'b0, 1'b0, "reset");
        checkState(1'b1, 1'b0, "resetL");
        rst_n = 1'b1;

        // Basic pair, one-cycle op_valid with op_ready high.
        sendStr(1'b0, "12\n07\n");
        expectPair(1'b0, 12, 7, 1'b0, "pair12_07");
        drive(1'b0, 1'b0, 8'h00);
        settle(1'b0, 2);

        // Overflowing operand reduced mod 32, then a clean max-value pair clears ovf.
        sendStr(1'b0, "45\n03\n");
        expectPair(1'b0, 13, 3, 1'b1, "pair45_03");
        sendStr(1'b0, "31\n31\n");
        expectPair(1'b0, 31, 31, 1'b0, "pair31_31");
        drive(1'b0, 1'b0, 8'h00);
        settle(1'b0, 1);

        // Malformed digit discards the pair; the following pair is delivered.
        sendStr(1'b0, "1a");
        observe(1'b0, ox, oy, ov, oe, oval, ordy);
        checkOutput("badDigit.err", 32'(oe), 32'd1);
        sendStr(1'b0, "\n05\n09\n");
        expectPair(1'b0, 5, 9, 1'b0, "pair05_09");
        drive(1'b0, 1'b0, 8'h00);
        settle(1'b0, 1);

        // Back-pressure: pair held while op_ready is low, next byte stalled.
        setOpReady(1'b0, 1'b0);
        sendStr(1'b0, "20\n10\n");
        drive(1'b0, 1'b1, 8'h35);
        settle(1'b0, 5);
        expectPair(1'b0, 20, 10, 1'b0, "hold20_10");
        setOpReady(1'b0, 1'b1);
        settle(1'b0, 1);
        drive(1'b0, 1'b0, 8'h00);
        settle(1'b0, 1);

        // Terminator rule: strict rejects 'x', lenient accepts any byte.
        sendStr(1'b0, "12x");
        observe(1'b0, ox, oy, ov, oe, oval, ordy);
        checkOutput("strictTerm.err", 32'(oe), 32'd1);
        drive(1'b0, 1'b0, 8'h00);
        settle(1'b0, 1);
        sendStr(1'b1, "12x34y");
        expectPair(1'b1, 12, 2, 1'b1, "lenient12_34");
        drive(1'b1, 1'b0, 8'h00);
        settle(1'b1, 1);

        // Reset in the middle of a pair.
        sendStr(1'b0, "9");
        drive(1'b0, 1'b0, 8'h00);
        #3 rst_n = 1'b0;
        #1;
        modelReset();
        checkState(1'b0, 1'b0, "midReset");
        #2 rst_n = 1'b1;
        settle(1'b0, 1);
        sendStr(1'b0, "01\n02\n");
        expectPair(1'b0, 1, 2, 1'b0, "pair01_02");
        drive(1'b0, 1'b0, 8'h00);
        settle(1'b0, 1);

        // Reset while a pair is pending drops op_valid immediately.
        setOpReady(1'b0, 1'b0);
        sendStr(1'b0, "11\n22\n");
        drive(1'b0, 1'b0, 8'h00);
        #2 rst_n = 1'b0;
        #1;
        observe(1'b0, ox, oy, ov, oe, oval, ordy);
        checkOutput("resetPending.op_valid", 32'(oval), 32'd0);
        modelReset();
        checkState(1'b0, 1'b0, "resetPending");
        #2 rst_n = 1'b1;
        setOpReady(1'b0, 1'b1);
        settle(1'b0, 1);

        // Random byte streams with occasional garbage and idle gaps, both terminator modes.
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 80; i++) begin
                if ($urandom_range(0, 9) == 0) b = 8'($urandom_range(0, 255));
                else if (mPos[k] == 2 || mPos[k] == 5)
                    b = (k == 1) ? 8'($urandom_range(0, 255)) : 8'h0A;
                else b = 8'(32'h30 + $urandom_range(0, 9));
                applyStimulus(k[0], b);
                if ($urandom_range(0, 3) == 0) begin
                    drive(k[0], 1'b0, 8'h00);
                    settle(k[0], int'($urandom_range(1, 2)));
                end
            end
            drive(k[0], 1'b0, 8'h00);
            settle(k[0], 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/operand_loader.md
Name: operand_loader

Overview:
Upstream input stage for the 5-bit ripple-carry adder datapath. Consumes an ASCII character stream with a valid/ready handshake. Parses two decimal operands, each written as two digits followed by a terminator, and presents them as a binary x/y pair to the adder with a valid/ready handshake. This replaces the behavioural character-reading code in the testbench with synthesizable RTL.

Parameters:
WIDTH, 5, operand width in bits; parsed value is reduced mod 2^WIDTH
STRICT_TERM, 1, 1: terminator byte must be 8'h0A; 0: any byte is accepted as terminator

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
ch_valid  input  1  character byte valid
ch_data  input  8  ASCII character
ch_ready  output  1  loader accepts ch_data this cycle
x  output  WIDTH  operand X, binary
y  output  WIDTH  operand Y, binary
op_valid  output  1  x/y pair valid
op_ready  input  1  adder side accepts pair
ovf  output  1  at least one operand of the current pair exceeded 2^WIDTH-1 before reduction
err  output  1  one-cycle pulse: malformed input, pair discarded

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values: state=X_TENS, x=0, y=0, op_valid=0, ovf=0, err=0, ch_ready=1. Reset mid-pair discards all partial data; no output pulse is generated.
- A byte is accepted when ch_valid && ch_ready are both high at a rising clk edge. A pair is transferred when op_valid && op_ready are both high at a rising clk edge.
- States: X_TENS, X_ONES, X_TERM, Y_TENS, Y_ONES, Y_TERM, OUT.
- ch_ready=1 in every state except OUT. op_valid=1 only in OUT.
- Digit states (X_TENS, X_ONES, Y_TENS, Y_ONES): a byte in the range 8'h30..8'h39 is a digit and advances the state. The digit d=ch_data-8'h30 is stored.
- Value computation: value=tens*10+ones, computed in 7 bits (range 0..99). The operand register receives value[WIDTH-1:0]. ovf is set if value>2^WIDTH-1. ovf is cleared when the next pair begins.
- TERM states: the accepted byte is checked against the terminator rule set by STRICT_TERM.
  - X_TERM advances to Y_TENS.
  - Y_TERM advances to OUT.
  - x/y are updated in the cycle the ones digit is accepted. They hold the previous pair's values until then.
- Latency: op_valid rises on the first clk edge after the Y terminator is accepted.
- OUT: x, y, and ovf are held stable while op_valid=1 && op_ready=0. On transfer, the next state is X_TENS, so ch_ready=1 on the following cycle. If op_ready is already high on entry, op_valid is high for exactly 1 cycle.
- Error cases: a non-digit in a digit state, or a wrong terminator when STRICT_TERM=1.
  - The byte is consumed (ch_ready was high).
  - err pulses high for the next cycle.
  - The state returns to X_TENS, and ovf is cleared.
  - x and y keep their last values, but op_valid is not asserted.
- ch_valid=0 in any parsing state: the state holds and no error is raised (idle gaps are legal).
- ch_valid during OUT: the byte is not accepted; the upstream source must hold it.
- Reset asserted while op_valid=1: op_valid drops asynchronously and the pair is lost.

Test Plan:
- Stream "12\n07\n" with ch_valid held high and op_ready=1 -> x=12, y=7, ovf=0, op_valid high 1 cycle, 1 cycle after the second '\n' is accepted.
- Stream "45\n03\n" -> x=13 (45 mod 32), y=3, ovf=1. Then stream "31\n31\n" -> x=31, y=31, ovf=0.
- Stream "1a\n" then "05\n09\n" -> err pulses 1 cycle after 'a' is accepted, no op_valid for the bad pair; the next pair is delivered as x=5, y=9.
- Stream "20\n10\n" with op_ready=0 for 5 cycles -> op_valid held, x=20, y=10 stable, ch_ready=0 while ch_valid=1 is presented; after op_ready=1, one transfer and ch_ready=1 on the next cycle.
- STRICT_TERM=1, stream "12x" -> err pulse, state X_TENS. Repeat with STRICT_TERM=0 and "12x34y" -> x=12, y=2 (34 mod 32), ovf=1.
- Assert rst_n=0 after "9" of "98\n" -> all outputs go to reset values immediately; then "01\n02\n" -> x=1, y=2.
